// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register addresses FIRST_ADDR..LAST_ADDR through a dedicated
// read port and streams each (address, data) pair over a valid/ready handshake.
// Optional feature macro: REG_DUMP_BYPASS_EN (same-cycle write-through at capture).
module reg_dump_reader #(
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] FirstAddr = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(LAST_ADDR);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [DATA_W-1:0] capture_data;
    logic              handshake;

    assign handshake = (state_q == StHold) && out_ready_i;

`ifdef REG_DUMP_BYPASS_EN
    // A write landing on the address being captured wins over the stale read data
    assign capture_data = (wr_en_i && (wr_addr_i == rd_addr_q)) ? wr_data_i : rd_data_i;
`else
    assign capture_data = rd_data_i;

    // Write snoop port is only consumed by the bypass build
    logic unused_wr;
    assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only honoured in idle, so a busy-time start is dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StFetch;
            StFetch: state_d = StHold;
            StHold: begin
                if (out_ready_i) begin
                    state_d = (rd_addr_q == LastAddr) ? StDone : StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        busy_o      = (state_q != StIdle);
        out_valid_o = (state_q == StHold);
        done_o      = (state_q == StDone);
    end

    // Datapath next-state: address walk and word capture
    always_comb begin
        rd_addr_d  = rd_addr_q;
        out_addr_d = out_addr_q;
        out_data_d = out_data_q;
        if ((state_q == StIdle) && start_i) begin
            rd_addr_d = FirstAddr;
        end
        if (handshake && (rd_addr_q != LastAddr)) begin
            rd_addr_d = rd_addr_q + 1'b1;
        end
        if (state_q == StFetch) begin
            out_addr_d = rd_addr_q;
            out_data_d = capture_data;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_addr_q  <= '0;
            out_addr_q <= '0;
            out_data_q <= '0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            out_addr_q <= out_addr_d;
            out_data_q <= out_data_d;
        end
    end

    assign rd_addr_o  = rd_addr_q;
    assign out_addr_o = out_addr_q;
    assign out_data_o = out_data_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dump, backpressure, start while busy,
// same-cycle write, mid-dump reset and an 8..15 subrange instance.
module tb_reg_dump_reader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start2;
    logic        out_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic        busy, out_valid, done;
    logic [4:0]  rd_addr, out_addr;
    logic [31:0] rd_data, out_data;

    logic        busy2, out_valid2, done2;
    logic [4:0]  rd_addr2, out_addr2;
    logic [31:0] rd_data2, out_data2;

    logic [31:0] regs [32];

    int n_checks = 0;
    int n_errors = 0;

    assign rd_data  = regs[rd_addr];
    assign rd_data2 = regs[rd_addr2];

    reg_dump_reader dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .busy_o      (busy),
        .rd_addr_o   (rd_addr),
        .rd_data_i   (rd_data),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_addr_o  (out_addr),
        .out_data_o  (out_data),
        .done_o      (done)
    );

    reg_dump_reader #(
        .FIRST_ADDR (8),
        .LAST_ADDR  (15)
    ) dut_sub (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start2),
        .busy_o      (busy2),
        .rd_addr_o   (rd_addr2),
        .rd_data_i   (rd_data2),
        .wr_en_i     (1'b0),
        .wr_addr_i   (5'd0),
        .wr_data_i   (32'd0),
        .out_valid_o (out_valid2),
        .out_ready_i (1'b1),
        .out_addr_o  (out_addr2),
        .out_data_o  (out_data2),
        .done_o      (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH for word addr; leaves it just after the handshake
    task automatic run_word(input int addr, input logic [31:0] data, input int stalls,
                            input bit do_start, input bit do_write);
        out_ready = (stalls == 0);
        if (do_start) start = 1'b1;
        if (do_write) begin
            wr_en   = 1'b1;
            wr_addr = 5'(addr);
            wr_data = 32'hDEAD_BEEF;
        end
        step();
        start = 1'b0;
        wr_en = 1'b0;
        check_eq($sformatf("w%0d valid", addr), 32'(out_valid), 32'd1);
        check_eq($sformatf("w%0d addr", addr), 32'(out_addr), 32'(addr));
        check_eq($sformatf("w%0d data", addr), out_data, data);
        for (int i = 0; i < stalls; i++) begin
            step();
            check_eq($sformatf("w%0d stall%0d valid", addr, i), 32'(out_valid), 32'd1);
            check_eq($sformatf("w%0d stall%0d addr", addr, i), 32'(out_addr), 32'(addr));
            check_eq($sformatf("w%0d stall%0d data", addr, i), out_data, data);
        end
        out_ready = 1'b1;
        step();
        check_eq($sformatf("w%0d valid drop", addr), 32'(out_valid), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start busy", 32'(busy), 32'd1);
        check_eq("start rd_addr", 32'(rd_addr), 32'd0);
        check_eq("start valid", 32'(out_valid), 32'd0);
    endtask

    task automatic finish_dump(input string tag);
        check_eq({tag, " done"}, 32'(done), 32'd1);
        check_eq({tag, " busy at done"}, 32'(busy), 32'd1);
        step();
        check_eq({tag, " done pulse end"}, 32'(done), 32'd0);
        check_eq({tag, " busy clear"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] exp_data;
        for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);
        reset     = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        out_ready = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        step();
        step();
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst rd_addr", 32'(rd_addr), 32'd0);
        check_eq("rst valid", 32'(out_valid), 32'd0);
        check_eq("rst out_addr", 32'(out_addr), 32'd0);
        check_eq("rst out_data", out_data, 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        reset = 1'b0;
        step();
        check_eq("idle busy", 32'(busy), 32'd0);

        // Full dump, sink always ready
        pulse_start();
        for (int k = 0; k < 32; k++) run_word(k, 32'h1000_0000 + 32'(k), 0, 1'b0, 1'b0);
        finish_dump("dump1");
        step();

        // Backpressure on word 5, same-cycle write on 7, ignored start on 10
        pulse_start();
        for (int k = 0; k < 32; k++) begin
            exp_data = 32'h1000_0000 + 32'(k);
`ifdef REG_DUMP_BYPASS_EN
            if (k == 7) exp_data = 32'hDEAD_BEEF;
`endif
            run_word(k, exp_data, (k == 5) ? 3 : 0, k == 10, k == 7);
        end
        finish_dump("dump2");
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("post dump2 done %0d", i), 32'(done), 32'd0);
            check_eq($sformatf("post dump2 busy %0d", i), 32'(busy), 32'd0);
        end

        // Reset while word 12 is held
        pulse_start();
        for (int k = 0; k < 12; k++) run_word(k, 32'h1000_0000 + 32'(k), 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        step();
        check_eq("pre-reset valid", 32'(out_valid), 32'd1);
        check_eq("pre-reset addr", 32'(out_addr), 32'd12);
        reset = 1'b1;
        #1;
        check_eq("midrst valid", 32'(out_valid), 32'd0);
        check_eq("midrst busy", 32'(busy), 32'd0);
        check_eq("midrst done", 32'(done), 32'd0);
        check_eq("midrst out_addr", 32'(out_addr), 32'd0);
        check_eq("midrst out_data", out_data, 32'd0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        check_eq("after rst done", 32'(done), 32'd0);
        pulse_start();
        for (int k = 0; k < 32; k++) run_word(k, 32'h1000_0000 + 32'(k), 0, 1'b0, 1'b0);
        finish_dump("dump3");

        // Subrange 8..15 instance: word handshakes at edges N+2..N+16
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check_eq("sub busy", 32'(busy2), 32'd1);
        check_eq("sub rd_addr", 32'(rd_addr2), 32'd8);
        for (int k = 8; k < 16; k++) begin
            step();
            check_eq($sformatf("sub w%0d valid", k), 32'(out_valid2), 32'd1);
            check_eq($sformatf("sub w%0d addr", k), 32'(out_addr2), 32'(k));
            check_eq($sformatf("sub w%0d data", k), out_data2, 32'h1000_0000 + 32'(k));
            step();
            check_eq($sformatf("sub w%0d valid drop", k), 32'(out_valid2), 32'd0);
        end
        check_eq("sub done", 32'(done2), 32'd1);
        step();
        check_eq("sub done end", 32'(done2), 32'd0);
        check_eq("sub busy clear", 32'(busy2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
